// File: rtl/adj_rtg_pkg.sv
// Shared types and helpers for the adaptive random test generation sequencer.
package adj_rtg_pkg;

  localparam logic [31:0] LFSR_MASK = 32'h80200003;
  localparam int VEC_W_DEF = 157;
  localparam int LFSR_WORDS = (VEC_W_DEF + 31) / 32;

  typedef enum logic [3:0] {
    IDLE,
    GEN,
    INJ,
    CMP,
    EVAL,
    COMMIT,
    COV,
    CHECK,
    DONE
  } rtgState_t;

  // Shrink the expectation after a weak vector, otherwise track the running mean.
  function automatic int unsigned expUpdate(input int unsigned newCnt, input int unsigned expCnt);
    return (newCnt < expCnt) ? (expCnt >> 1) : ((newCnt + expCnt) >> 1);
  endfunction

endpackage

// File: rtl/adj_rtg_lfsr32.sv
// 32-bit Galois LFSR; one step per cycle while step is high, load has priority.
module rtg_lfsr32
  import adj_rtg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] seed,
  output logic [31:0] state
);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= '0;
    end else if (load) begin
      state <= (seed == 32'h0) ? 32'h1 : seed;
    end else if (step) begin
      state <= {1'b0, state[31:1]} ^ (state[0] ? LFSR_MASK : 32'h0);
    end
  end

endmodule

// File: rtl/adj_rtg_controller.sv
// Adaptive random test generation sequencer: builds vectors, sweeps every fault through
// the harness (waits unboundedly on inj_ack), keeps vectors that find enough new faults.
module adj_rtg_controller
  import adj_rtg_pkg::*;
#(
  parameter int NUM_FAULTS  = 1798,
  parameter int FIDX_W      = 11,
  parameter int VEC_W       = 157,
  parameter int OUT_W       = 64,
  parameter int INIT_EXP    = 2,
  parameter int UT_LIMIT    = 20,
  parameter int DESIRED_COV = 90
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       seed,
  output logic [VEC_W-1:0]  test_vec,
  output logic [FIDX_W-1:0] fault_idx,
  output logic              inj_req,
  input  logic              inj_ack,
  input  logic [OUT_W-1:0]  good_out,
  input  logic [OUT_W-1:0]  faulty_out,
  output logic              keep_vld,
  output logic              busy,
  output logic              done,
  output logic [6:0]        coverage,
  output logic [15:0]       kept_cnt,
  output logic [15:0]       total_cnt
);

  localparam int CNT_W = FIDX_W + 1;
  localparam int NUM_W = CNT_W + 7;
  localparam logic [7:0]        LAST_WORD = 8'((VEC_W + 31) / 32 - 1);
  localparam logic [FIDX_W-1:0] LAST_IDX  = FIDX_W'(NUM_FAULTS);
  localparam logic [CNT_W-1:0]  EXP_INIT  = CNT_W'(INIT_EXP);
  localparam logic [NUM_W-1:0]  NF_DIV    = NUM_W'(NUM_FAULTS);
  localparam logic [6:0]        COV_TGT   = 7'(DESIRED_COV);
  localparam logic [15:0]       UT_LIM    = 16'(UT_LIMIT);

  rtgState_t               state;
  logic [7:0]              genCnt;
  logic [CNT_W-1:0]        expCnt;
  logic [CNT_W-1:0]        expNext;
  logic [CNT_W-1:0]        newCnt;
  logic [CNT_W-1:0]        detCnt;
  logic [15:0]             utCnt;
  logic                    keepR;
  logic [NUM_FAULTS-1:0]   atMap;
  logic [NUM_FAULTS-1:0]   ctMap;
  logic [NUM_FAULTS-1:0]   faultHot;
  logic                    curAt;
  logic [NUM_W-1:0]        covRem;
  logic [6:0]              covQ;
  logic [31:0]             lfsrState;

  rtg_lfsr32 uLfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (state == IDLE && start),
    .step  (state == GEN),
    .seed  (seed),
    .state (lfsrState)
  );

  // Fault index is 1-based; bit i of the maps belongs to fault i+1.
  always_comb begin
    faultHot = '0;
    for (int i = 0; i < NUM_FAULTS; i++) begin
      faultHot[i] = (fault_idx == FIDX_W'(i + 1));
    end
    curAt   = |(atMap & faultHot);
    expNext = CNT_W'(expUpdate(32'(newCnt), 32'(expCnt)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      genCnt    <= '0;
      expCnt    <= EXP_INIT;
      newCnt    <= '0;
      detCnt    <= '0;
      utCnt     <= '0;
      keepR     <= 1'b0;
      atMap     <= '0;
      ctMap     <= '0;
      covRem    <= '0;
      covQ      <= '0;
      test_vec  <= '0;
      fault_idx <= '0;
      inj_req   <= 1'b0;
      keep_vld  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      coverage  <= '0;
      kept_cnt  <= '0;
      total_cnt <= '0;
    end else begin
      keep_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= GEN;
            genCnt    <= '0;
            expCnt    <= EXP_INIT;
            newCnt    <= '0;
            detCnt    <= '0;
            utCnt     <= '0;
            atMap     <= '0;
            ctMap     <= '0;
            coverage  <= '0;
            kept_cnt  <= '0;
            total_cnt <= '0;
            done      <= 1'b0;
            busy      <= 1'b1;
          end
        end
        GEN: begin
          test_vec <= VEC_W'({test_vec, lfsrState});
          genCnt   <= genCnt + 8'd1;
          if (genCnt == LAST_WORD) begin
            total_cnt <= (total_cnt == 16'hFFFF) ? total_cnt : total_cnt + 16'd1;
            utCnt     <= utCnt + 16'd1;
            fault_idx <= FIDX_W'(1);
            newCnt    <= '0;
            ctMap     <= '0;
            inj_req   <= 1'b1;
            state     <= INJ;
          end
        end
        INJ: begin
          if (inj_ack) begin
            inj_req <= 1'b0;
            state   <= CMP;
          end
        end
        CMP: begin
          if (good_out != faulty_out) begin
            ctMap <= ctMap | faultHot;
            if (!curAt) newCnt <= newCnt + CNT_W'(1);
          end
          if (fault_idx == LAST_IDX) begin
            state <= EVAL;
          end else begin
            fault_idx <= fault_idx + FIDX_W'(1);
            inj_req   <= 1'b1;
            state     <= INJ;
          end
        end
        EVAL: begin
          expCnt <= expNext;
          keepR  <= (newCnt >= expNext) && (newCnt != '0);
          state  <= COMMIT;
        end
        COMMIT: begin
          if (keepR) begin
            atMap    <= atMap | ctMap;
            detCnt   <= detCnt + newCnt;
            kept_cnt <= (kept_cnt == 16'hFFFF) ? kept_cnt : kept_cnt + 16'd1;
            utCnt    <= '0;
            keep_vld <= 1'b1;
            covRem   <= NUM_W'(detCnt + newCnt) * NUM_W'(100);
            covQ     <= '0;
            state    <= COV;
          end else begin
            state <= CHECK;
          end
        end
        COV: begin
          // Quotient of 100*det/NUM_FAULTS never exceeds 100, so this settles within 101 cycles.
          if (covRem >= NF_DIV) begin
            covRem <= covRem - NF_DIV;
            covQ   <= covQ + 7'd1;
          end else begin
            coverage <= covQ;
            state    <= CHECK;
          end
        end
        CHECK: begin
          if (coverage >= COV_TGT || utCnt >= UT_LIM) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            genCnt <= '0;
            state  <= GEN;
          end
        end
        DONE: begin
          if (start) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adj_rtg_controller.sv
// Bench for adj_rtg_controller: stub fault harness driven from per-vector fault masks.
module tb_adj_rtg_controller;

  localparam int NF = 8;
  localparam int FIDX_W = 11;
  localparam int VEC_W = 157;
  localparam int OUT_W = 64;
  localparam int UTL = 3;
  localparam int DCOV = 90;
  localparam int WORDS = (VEC_W + 31) / 32;
  localparam int BUDGET = 20000;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [31:0]       seed = '0;
  logic [VEC_W-1:0]  test_vec;
  logic [FIDX_W-1:0] fault_idx;
  logic              inj_req;
  logic              inj_ack = 1'b0;
  logic [OUT_W-1:0]  good_out = '0;
  logic [OUT_W-1:0]  faulty_out = '0;
  logic              keep_vld;
  logic              busy;
  logic              done;
  logic [6:0]        coverage;
  logic [15:0]       kept_cnt;
  logic [15:0]       total_cnt;

  always #5 clk = ~clk;

  adj_rtg_controller #(
    .NUM_FAULTS(NF), .FIDX_W(FIDX_W), .VEC_W(VEC_W), .OUT_W(OUT_W),
    .INIT_EXP(2), .UT_LIMIT(UTL), .DESIRED_COV(DCOV)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed),
    .test_vec(test_vec), .fault_idx(fault_idx), .inj_req(inj_req), .inj_ack(inj_ack),
    .good_out(good_out), .faulty_out(faulty_out), .keep_vld(keep_vld), .busy(busy),
    .done(done), .coverage(coverage), .kept_cnt(kept_cnt), .total_cnt(total_cnt)
  );

  int nChecks = 0;
  int nFails = 0;

  // Stub harness: vecMask[v] bit f-1 set means fault f is detected by vector v.
  logic [NF-1:0] vecMask [64];
  int  vecIdx = 0;
  int  stallIdx = 0;
  bit  pending = 0;
  int  dly = 0;

  always @(negedge clk) begin
    if (rst || start) vecIdx = 0;
    if (!inj_req) begin
      inj_ack = 1'b0;
      pending = 0;
    end else begin
      if (!pending) begin
        pending = 1;
        dly = (vecIdx == 0 && int'(fault_idx) == stallIdx) ? 10 : int'($urandom_range(0, 2));
      end
      if (!inj_ack) begin
        if (dly == 0) begin
          good_out   = {$urandom, $urandom};
          faulty_out = vecMask[vecIdx][int'(fault_idx) - 1] ?
                       good_out ^ (64'h1 << $urandom_range(0, 63)) : good_out;
          inj_ack    = 1'b1;
          if (int'(fault_idx) == NF && vecIdx < 63) vecIdx++;
        end else begin
          dly--;
        end
      end
    end
  end

  // Reference model: whole-run outcome computed from the selection rules.
  logic [VEC_W-1:0] expVecs [64];
  bit               expKeep [64];
  int               expCov  [64];
  int               expN, expKept;

  function automatic logic [31:0] lfsrNext(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
  endfunction

  task automatic modelRun(input logic [31:0] sd);
    logic [31:0] l;
    logic [NF-1:0] at;
    logic [VEC_W-1:0] v;
    int expc, ut, det, cov, nw;
    l = (sd == 0) ? 32'h1 : sd;
    at = '0; expc = 2; ut = 0; det = 0; cov = 0; expN = 0; expKept = 0;
    while (expN < 64) begin
      v = '0;
      for (int w = 0; w < WORDS; w++) begin
        v = (v << 32) | VEC_W'(l);
        l = lfsrNext(l);
      end
      ut++;
      nw = $countones(vecMask[expN] & ~at);
      expc = (nw < expc) ? expc / 2 : (nw + expc) / 2;
      expVecs[expN] = v;
      expKeep[expN] = (nw >= expc) && (nw > 0);
      if (expKeep[expN]) begin
        at |= vecMask[expN];
        det += nw;
        expKept++;
        ut = 0;
        cov = det * 100 / NF;
      end
      expCov[expN] = cov;
      expN++;
      if (cov >= DCOV || ut >= UTL) break;
    end
  endtask

  // Observations gathered per run.
  logic [VEC_W-1:0] obsVecs [64];
  bit               obsKeep [64];
  int               covAtVec [64];

  task automatic doReset();
    rst = 1'b1; start = 1'b0; stallIdx = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic pulseStart(input logic [31:0] s);
    @(posedge clk); #1;
    seed = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic runVectors(output bit timedOut, output int nVec);
    bit prevReq;
    prevReq = 0; nVec = 0; timedOut = 1;
    for (int c = 0; c < BUDGET; c++) begin
      @(posedge clk); #1;
      if (inj_req && !prevReq && fault_idx == 1 && nVec < 64) begin
        obsVecs[nVec] = test_vec;
        covAtVec[nVec] = int'(coverage);
        obsKeep[nVec] = 0;
        nVec++;
      end
      if (keep_vld && nVec > 0) obsKeep[nVec-1] = 1;
      prevReq = inj_req;
      if (done) begin
        timedOut = 0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    doReset();
    nChecks++;
    if ({inj_req, keep_vld, busy, done} !== 4'b0) begin
      nFails++; $display("FAIL reset_flags: got %b expected 0000", {inj_req, keep_vld, busy, done});
    end
    nChecks++;
    if ({coverage, kept_cnt, total_cnt} !== 39'h0) begin
      nFails++; $display("FAIL reset_counts: got cov=%0d kept=%0d total=%0d expected 0", coverage, kept_cnt, total_cnt);
    end
    nChecks++;
    if (test_vec !== '0 || fault_idx !== '0) begin
      nFails++; $display("FAIL reset_vec_idx: got vec=%h idx=%0d expected 0", test_vec, fault_idx);
    end
  endtask

  task automatic test_keep_reject();
    bit to; int n;
    logic [31:0] s;
    doReset();
    vecMask[0] = 8'h0F;
    vecMask[1] = 8'h0F;
    for (int i = 2; i < 64; i++) vecMask[i] = NF'($urandom_range(0, 255));
    s = $urandom;
    modelRun(s);
    pulseStart(s);
    runVectors(to, n);
    nChecks++;
    if (to) begin nFails++; $display("FAIL keep_reject_timeout: got no done within %0d cycles", BUDGET); end
    nChecks++;
    if (n !== expN) begin nFails++; $display("FAIL keep_reject_nvec: got %0d expected %0d", n, expN); end
    nChecks++;
    if (obsKeep[0] !== 1'b1 || (n > 1 && obsKeep[1] !== 1'b0)) begin
      nFails++; $display("FAIL keep_then_reject: got keep0=%0d keep1=%0d expected 1 0", obsKeep[0], obsKeep[1]);
    end
    if (n > 2) begin
      nChecks++;
      if (covAtVec[1] !== 50 || covAtVec[2] !== 50) begin
        nFails++; $display("FAIL cov_after_v1_v2: got %0d %0d expected 50 50", covAtVec[1], covAtVec[2]);
      end
    end
    for (int i = 0; i < n && i < expN; i++) begin
      nChecks++;
      if (obsVecs[i] !== expVecs[i]) begin
        nFails++; $display("FAIL kr_vec%0d: got %h expected %h", i, obsVecs[i], expVecs[i]);
      end
      nChecks++;
      if (obsKeep[i] !== expKeep[i]) begin
        nFails++; $display("FAIL kr_keep%0d: got %0d expected %0d", i, obsKeep[i], expKeep[i]);
      end
      if (i > 0) begin
        nChecks++;
        if (covAtVec[i] !== expCov[i-1]) begin
          nFails++; $display("FAIL kr_cov%0d: got %0d expected %0d", i, covAtVec[i], expCov[i-1]);
        end
      end
    end
    nChecks++;
    if (int'(kept_cnt) !== expKept || int'(total_cnt) !== expN || int'(coverage) !== expCov[expN-1]) begin
      nFails++; $display("FAIL kr_final: got kept=%0d total=%0d cov=%0d expected %0d %0d %0d",
                         kept_cnt, total_cnt, coverage, expKept, expN, expCov[expN-1]);
    end
  endtask

  task automatic test_no_mismatch();
    bit to; int n; int keeps;
    logic [31:0] s;
    doReset();
    for (int i = 0; i < 64; i++) vecMask[i] = '0;
    s = 32'h0;
    modelRun(s);
    pulseStart(s);
    runVectors(to, n);
    keeps = 0;
    for (int i = 0; i < n; i++) keeps += int'(obsKeep[i]);
    nChecks++;
    if (to || total_cnt !== 16'd3 || n !== 3) begin
      nFails++; $display("FAIL nomis_total: got timeout=%0d total=%0d nvec=%0d expected 0 3 3", to, total_cnt, n);
    end
    nChecks++;
    if (kept_cnt !== 16'd0 || coverage !== 7'd0 || keeps !== 0) begin
      nFails++; $display("FAIL nomis_keeps: got kept=%0d cov=%0d pulses=%0d expected 0 0 0", kept_cnt, coverage, keeps);
    end
    nChecks++;
    if (obsVecs[0] !== expVecs[0]) begin
      nFails++; $display("FAIL nomis_zero_seed_vec: got %h expected %h", obsVecs[0], expVecs[0]);
    end
    pulseStart(32'h1234);
    nChecks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      nFails++; $display("FAIL done_to_idle: got done=%0d busy=%0d expected 0 0", done, busy);
    end
  endtask

  task automatic test_full_cov();
    bit to; int n;
    logic [31:0] s;
    doReset();
    for (int i = 0; i < 64; i++) vecMask[i] = NF'($urandom_range(0, 255));
    vecMask[0] = 8'hFF;
    s = $urandom;
    modelRun(s);
    pulseStart(s);
    runVectors(to, n);
    nChecks++;
    if (to || total_cnt !== 16'd1 || kept_cnt !== 16'd1 || obsKeep[0] !== 1'b1) begin
      nFails++; $display("FAIL fullcov_counts: got to=%0d total=%0d kept=%0d keep=%0d expected 0 1 1 1",
                         to, total_cnt, kept_cnt, obsKeep[0]);
    end
    nChecks++;
    if (coverage !== 7'd100 || busy !== 1'b0) begin
      nFails++; $display("FAIL fullcov_cov: got cov=%0d busy=%0d expected 100 0", coverage, busy);
    end
    nChecks++;
    if (obsVecs[0] !== expVecs[0]) begin
      nFails++; $display("FAIL fullcov_vec: got %h expected %h", obsVecs[0], expVecs[0]);
    end
  endtask

  task automatic test_ack_stall();
    bit hit, stable; int hi;
    logic [VEC_W-1:0] v;
    doReset();
    for (int i = 0; i < 64; i++) vecMask[i] = NF'($urandom_range(0, 255));
    stallIdx = 5;
    pulseStart($urandom);
    hit = 0;
    for (int c = 0; c < 500 && !hit; c++) begin
      @(posedge clk); #1;
      if (inj_req && fault_idx == 5) hit = 1;
    end
    nChecks++;
    if (!hit) begin nFails++; $display("FAIL stall_reach: got no request at fault 5 expected one"); end
    v = test_vec; hi = 0; stable = 1;
    while (inj_req && hi < 40) begin
      if (fault_idx !== 11'd5 || test_vec !== v) stable = 0;
      hi++;
      @(posedge clk); #1;
    end
    nChecks++;
    if (hi !== 11) begin nFails++; $display("FAIL stall_len: got %0d request cycles expected 11", hi); end
    nChecks++;
    if (!stable) begin nFails++; $display("FAIL stall_stable: got idx/vec change expected stable"); end
    nChecks++;
    if (inj_ack !== 1'b1 || fault_idx !== 11'd5) begin
      nFails++; $display("FAIL stall_cmp: got ack=%0d idx=%0d expected 1 5", inj_ack, fault_idx);
    end
    @(posedge clk); #1;
    nChecks++;
    if (inj_req !== 1'b1 || fault_idx !== 11'd6) begin
      nFails++; $display("FAIL stall_next: got req=%0d idx=%0d expected 1 6", inj_req, fault_idx);
    end
    stallIdx = 0;
  endtask

  task automatic test_reset_midop();
    bit hit, to; int n;
    logic [31:0] s;
    doReset();
    for (int i = 0; i < 64; i++) vecMask[i] = NF'($urandom_range(0, 255));
    s = $urandom;
    pulseStart(s);
    hit = 0;
    for (int c = 0; c < 500 && !hit; c++) begin
      @(posedge clk); #1;
      if (inj_req && fault_idx == 3) hit = 1;
    end
    nChecks++;
    if (!hit) begin nFails++; $display("FAIL midrst_reach: got no request at fault 3 expected one"); end
    rst = 1'b1;
    @(posedge clk); #1;
    nChecks++;
    if (inj_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      nFails++; $display("FAIL midrst_flags: got req=%0d busy=%0d done=%0d expected 0 0 0", inj_req, busy, done);
    end
    nChecks++;
    if (total_cnt !== 16'd0 || kept_cnt !== 16'd0 || coverage !== 7'd0) begin
      nFails++; $display("FAIL midrst_counts: got total=%0d kept=%0d cov=%0d expected 0", total_cnt, kept_cnt, coverage);
    end
    rst = 1'b0;
    modelRun(s);
    pulseStart(s);
    runVectors(to, n);
    nChecks++;
    if (to || n !== expN) begin nFails++; $display("FAIL midrst_rerun: got to=%0d nvec=%0d expected 0 %0d", to, n, expN); end
    for (int i = 0; i < n && i < expN; i++) begin
      nChecks++;
      if (obsVecs[i] !== expVecs[i] || obsKeep[i] !== expKeep[i]) begin
        nFails++; $display("FAIL midrst_vec%0d: got %h/%0d expected %h/%0d", i, obsVecs[i], obsKeep[i], expVecs[i], expKeep[i]);
      end
    end
    nChecks++;
    if (int'(kept_cnt) !== expKept || int'(coverage) !== expCov[expN-1]) begin
      nFails++; $display("FAIL midrst_final: got kept=%0d cov=%0d expected %0d %0d", kept_cnt, coverage, expKept, expCov[expN-1]);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) vecMask[i] = '0;
    test_reset();
    test_keep_reject();
    test_no_mismatch();
    test_full_cov();
    test_ack_stall();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/adj_rtg_controller.md
Name: adj_rtg_controller

Overview:
- Synthesizable sequencer for adaptive (adjustable-threshold) random test generation on the fault-simulation harness.
- Generates pseudo-random test vectors and steps an external fault injector through every fault index. It compares good-circuit and faulty-circuit outputs, keeps only vectors that discover enough new faults, and stops on a coverage target or a useless-vector limit.
- Sits between the fault-injection harness (good/faulty CUT pair) and the test-vector store.

Parameters:
- NUM_FAULTS, 1798, number of faults in the fault list; indices 1..NUM_FAULTS.
- FIDX_W, 11, width of the fault index.
- VEC_W, 157, test vector width (CUT primary inputs).
- OUT_W, 64, CUT primary output width.
- INIT_EXP, 2, initial expected new-fault count.
- UT_LIMIT, 20, consecutive rejected vectors before giving up.
- DESIRED_COV, 90, target coverage in percent.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins a run from IDLE, ignored elsewhere
- seed  in  32  LFSR seed, sampled on start; value 0 is replaced by 32'h1
- test_vec  out  VEC_W  current vector driven to both CUTs
- fault_idx  out  FIDX_W  fault to inject
- inj_req  out  1  request: inject fault_idx, apply test_vec
- inj_ack  in  1  harness: fault injected and outputs settled
- good_out  in  OUT_W  fault-free CUT outputs
- faulty_out  in  OUT_W  faulty CUT outputs
- keep_vld  out  1  one-cycle pulse; test_vec accepted for storage
- busy  out  1  high from start until done
- done  out  1  level, set at termination, cleared by start or rst
- coverage  out  7  floor(100*detected/NUM_FAULTS)
- kept_cnt  out  16  accepted vectors
- total_cnt  out  16  generated vectors

Behaviour:
- Reset: state IDLE. All outputs 0. Internal exp_cnt=INIT_EXP, ut_cnt=0, detected bitmaps and counters cleared. Reset mid-operation aborts immediately; inj_req is 0 the next cycle.
- FSM states: IDLE, GEN, INJ, CMP, EVAL, COMMIT, COV, CHECK, DONE.
- IDLE -> GEN on start. start also clears all counters and bitmaps, clears done and loads the LFSR.
- LFSR: 32-bit Galois, mask 32'h80200003.
- GEN: lasts ceil(VEC_W/32) cycles. Each cycle the LFSR advances once; test_vec <= {test_vec, lfsr} truncated to VEC_W.
- On GEN exit: total_cnt++, ut_cnt++, fault_idx=1, new_cnt=0, ct_map cleared.
- INJ: inj_req=1. fault_idx and test_vec are held stable until inj_ack=1; wait is unbounded. Then go to CMP; inj_req drops the same cycle.
- CMP (1 cycle): if good_out != faulty_out, set ct_map[fault_idx], and new_cnt++ if at_map[fault_idx]==0.
- From CMP: if fault_idx==NUM_FAULTS go to EVAL; otherwise fault_idx++ and return to INJ.
- EVAL: if new_cnt < exp_cnt, exp_cnt <= exp_cnt>>1; else exp_cnt <= (new_cnt+exp_cnt)>>1. Widths are FIDX_W+1, no overflow possible.
- Acceptance: keep iff new_cnt >= updated exp_cnt AND new_cnt > 0. Comparison uses the updated value, registered in EVAL and applied in COMMIT.
- COMMIT (1 cycle):
  - On keep: at_map |= ct_map, det_cnt += new_cnt, kept_cnt++, ut_cnt=0, keep_vld=1 with test_vec valid. Then COV.
  - On reject: go to CHECK.
- COV: coverage = floor(100*det_cnt/NUM_FAULTS), computed by repeated subtraction, at most 101 cycles. coverage is updated only at the end.
- CHECK: if coverage >= DESIRED_COV or ut_cnt >= UT_LIMIT, go to DONE; else GEN.
- DONE: done=1, busy=0. Go to IDLE on the next start.
- Counter wrap: kept_cnt and total_cnt saturate at 16'hFFFF.
- inj_ack asserted outside INJ is ignored.

Decomposition:
- Package adj_rtg_pkg:
  - state enum
  - LFSR_MASK
  - LFSR_WORDS = (VEC_W+31)/32
  - helper function for exp_cnt update
- One natural sub-module: rtg_lfsr32, with load, step, seed and state ports.
- Coverage division stays inline.

Test Plan:
- Stub harness: NUM_FAULTS=8. Vector 1 mismatches faults 1-4.
  - Expected: exp 2->3, keep, keep_vld pulse, det=4, coverage=50, kept_cnt=1.
- Same stub, vector 2 mismatches only faults 1-4 again.
  - Expected: new=0, exp 3->1, reject, ut_cnt=1, coverage remains 50.
- NUM_FAULTS=8, UT_LIMIT=3, stub never mismatches.
  - Expected: exp 2->1->0->0, no keeps (new>0 rule), done after total_cnt=3, kept_cnt=0, coverage=0.
- NUM_FAULTS=8, DESIRED_COV=90, vector 1 mismatches all 8.
  - Expected: keep, coverage=100, done after exactly 1 vector.
- inj_ack held low 10 cycles on fault 5.
  - Expected: inj_req, fault_idx=5 and test_vec stable throughout; CMP occurs one cycle after ack.
- rst asserted while inj_req=1 at fault 3.
  - Expected: next cycle inj_req=0, busy=0, all counters 0, state IDLE. A fresh start with the same seed reproduces an identical test_vec sequence.
